// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin arbiter feeding one UART_TX serializer, with watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 d_in,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_FIRE = CNTW'(TIMEOUT_CYCLES - 2);
  localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0]  LAST_IDX = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e          state_q,  state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q,  grant_d;
  logic [7:0]      d_in_q,   d_in_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;
  logic            err_q,    err_d;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    cand;

  // Scan downward so the last hit kept is the nearest valid at/after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    d_in_d    = d_in_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req_ready = '0;
    tx_start  = 1'b0;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready = NUM_REQ'(1) << win_idx;
          d_in_d    = req_data[{win_idx, 3'b000} +: 8];
          grant_d   = win_idx;
          rr_ptr_d  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Completion beats a watchdog expiry landing on the same cycle.
        if (tx_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_FIRE) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      d_in_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      d_in_q   <= d_in_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign d_in        = d_in_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench; the bench plays the UART_TX side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  d_in;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_xfer  = 0;
  int model_ptr = 0;
  bit exp_err   = 1'b0;

  uart_tx_sched #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .d_in(d_in), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (resetn === 1'b1 && tx_start === 1'b1) n_start++;

  // Winner: first valid requester found walking up from the pointer, wrapping.
  function automatic int model_winner(input logic [3:0] v, input int ptr);
    for (int i = 0; i < 4; i++) if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; #3; resetn = 1'b1;
    model_ptr = 0; exp_err = 1'b0;
    step();
  endtask

  // One full accept/launch/wait/done transaction with timing checks.
  task automatic send_one(input logic [3:0] v, input logic [31:0] data,
                          input int dly, input bit stray);
    int w; logic [1:0] w2; logic [3:0] exp_rdy; logic [7:0] byt;
    logic [15:0] got, exp;
    w = model_winner(v, model_ptr); w2 = w[1:0];
    exp_rdy = 4'b0001 << w; byt = data[w*8 +: 8];
    req_valid = v; req_data = data; #1;
    n_chk++;
    if (req_ready !== exp_rdy) begin
      n_fail++; $display("FAIL idle_ready: got %b expected %b", req_ready, exp_rdy);
    end
    step();
    req_valid = '0; req_data = $urandom; tx_done = stray; #1;
    model_ptr = (w + 1) % 4; n_xfer++;
    got = {tx_start, busy, req_ready, grant_id, d_in};
    exp = {1'b1, 1'b1, 4'b0000, w2, byt};
    n_chk++;
    if (got !== exp) begin
      n_fail++; $display("FAIL launch {start,busy,ready,grant,d_in}: got %h expected %h", got, exp);
    end
    step(); tx_done = 1'b0; #1;
    n_chk++;
    if ({tx_start, busy} !== 2'b01) begin
      n_fail++; $display("FAIL wait0 {start,busy}: got %b expected 01", {tx_start, busy});
    end
    repeat (dly) step();
    tx_done = 1'b1; step(); tx_done = 1'b0; #1;
    got = {3'b000, busy, d_in, grant_id, timeout_err, 1'b0};
    exp = {3'b000, 1'b0, byt, w2, exp_err, 1'b0};
    n_chk++;
    if (got !== exp) begin
      n_fail++; $display("FAIL done {busy,d_in,grant,err}: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0; err_clr = 1'b0;
    #3;
    n_chk++;
    if ({busy, tx_start, d_in, grant_id, timeout_err, req_ready} !== 17'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
                         {busy, tx_start, d_in, grant_id, timeout_err, req_ready});
    end
    req_valid = 4'b0100; #1;
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0100", req_ready);
    end
    req_valid = '0; #1; resetn = 1'b1; model_ptr = 0; exp_err = 1'b0;
    step();
  endtask

  task automatic test_single();
    send_one(4'b0010, 32'h0000_A500, 6, 1'b0);
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 5; i++) send_one(4'hF, 32'h1312_1110, $urandom_range(0, 8), 1'b0);
  endtask

  task automatic test_wrap_skip();
    send_one(4'b0100, 32'h4433_2211, 3, 1'b0);
    send_one(4'b1001, 32'hD4C3_B2A1, 2, 1'b0);
    send_one(4'b1001, 32'hD4C3_B2A1, 5, 1'b0);
  endtask

  task automatic test_stray_done();
    req_valid = '0; tx_done = 1'b1; step(); tx_done = 1'b0; #1;
    n_chk++;
    if ({busy, tx_start} !== 2'b00) begin
      n_fail++; $display("FAIL stray_idle {busy,start}: got %b expected 00", {busy, tx_start});
    end
    send_one(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 14), 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      send_one(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 14),
               1'($urandom_range(0, 1)));
  endtask

  // Drives an accept and lets the watchdog expire; ends at first cycle back in IDLE - 1.
  task automatic start_no_done(input logic [3:0] v);
    int w;
    w = model_winner(v, model_ptr);
    req_valid = v; req_data = $urandom;
    step(); req_valid = '0; model_ptr = (w + 1) % 4; n_xfer++;
    step();
    repeat (14) step();
  endtask

  task automatic test_timeout();
    start_no_done(4'($urandom_range(1, 15)));
    n_chk++;
    if ({busy, timeout_err} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_w14 {busy,err}: got %b expected 10", {busy, timeout_err});
    end
    step();
    n_chk++;
    if ({busy, timeout_err} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_w15 {busy,err}: got %b expected 01", {busy, timeout_err});
    end
    exp_err = 1'b1;
    send_one(4'($urandom_range(1, 15)), $urandom, 14, 1'b0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_chk++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clr: got %b expected 0", timeout_err);
    end
    exp_err = 1'b0;
    err_clr = 1'b1;
    start_no_done(4'($urandom_range(1, 15)));
    step();
    n_chk++;
    if (timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clr: got %b expected 1", timeout_err);
    end
    step(); err_clr = 1'b0;
    n_chk++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL clr_after_set: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    start_no_done(4'b1000);
    step();
    req_valid = 4'b0010; req_data = 32'h0000_C300;
    step(); req_valid = '0; n_xfer++;
    step(); step();
    #2 resetn = 1'b0; #1;
    n_chk++;
    if ({busy, tx_start, d_in, grant_id, timeout_err, req_ready} !== 17'h0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected 0",
                         {busy, tx_start, d_in, grant_id, timeout_err, req_ready});
    end
    #2 resetn = 1'b1; model_ptr = 0; exp_err = 1'b0;
    step();
    send_one(4'b0110, 32'h0077_6600, 4, 1'b0);
    send_one(4'b0100, 32'h0099_8800, 4, 1'b0);
  endtask

  task automatic test_start_count();
    n_chk++;
    if (n_start !== n_xfer) begin
      n_fail++; $display("FAIL start_count: got %0d expected %0d", n_start, n_xfer);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_stray_done();
    test_random();
    test_timeout();
    test_reset_mid();
    test_start_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL sim_time_limit: got expired expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
